// File: rtl/load_fu.sv
// rtl/load_fu.sv - load functional unit: picks a busy RS load line, reads memory, extends and offers result to CDB
module load_fu #(
    parameter int NUM_LINES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [NUM_LINES-1:0]   line_busy,
    input  logic [32*NUM_LINES-1:0] line_addr,
    input  logic [3*NUM_LINES-1:0] line_type,
    output logic [NUM_LINES-1:0]   FU_result_taken,
    output logic                   mem_req,
    output logic [31:0]            mem_addr,
    input  logic                   mem_ack,
    input  logic                   mem_rvalid,
    input  logic [31:0]            mem_rdata,
    output logic                   result_valid,
    output logic [2:0]             result_line,
    output logic [31:0]            result_data,
    input  logic                   cdb_grant
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state;
    logic [2:0]  cur_idx;
    logic [1:0]  cur_lane;
    logic [2:0]  cur_type;

    logic        pick_found;
    logic [2:0]  pick_idx;
    logic [31:0] pick_addr;
    logic [2:0]  pick_type;

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ext_data;
    logic        take;

    // Lowest-index busy line wins; scanning downward lets the lowest index overwrite the rest.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        pick_addr  = 32'd0;
        pick_type  = 3'd0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (line_busy[i]) begin
                pick_found = 1'b1;
                pick_idx   = 3'(i);
                pick_addr  = line_addr[32*i +: 32];
                pick_type  = line_type[3*i +: 3];
            end
        end
    end

    // Lane extraction and sign/zero extension of the returned word; size code 11 behaves as word.
    always_comb begin
        byte_v   = mem_rdata[8*cur_lane +: 8];
        half_v   = mem_rdata[16*cur_lane[1] +: 16];
        ext_data = mem_rdata;
        case (cur_type[1:0])
            2'b00:   ext_data = cur_type[2] ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   ext_data = cur_type[2] ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
            default: ext_data = mem_rdata;
        endcase
    end

    // One-hot acknowledge to the serviced line in the grant cycle; a flush suppresses it.
    always_comb begin
        take = (state == S_DONE) && cdb_grant && !flush && !rst;
        for (int i = 0; i < NUM_LINES; i++) begin
            FU_result_taken[i] = take && (result_line == 3'(i));
        end
    end

    // Single-outstanding load sequencer with registered memory and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            mem_req      <= 1'b0;
            mem_addr     <= 32'd0;
            result_valid <= 1'b0;
            result_line  <= 3'd0;
            result_data  <= 32'd0;
            cur_idx      <= 3'd0;
            cur_lane     <= 2'd0;
            cur_type     <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    mem_req      <= 1'b0;
                    result_valid <= 1'b0;
                    if (!flush && pick_found) begin
                        cur_idx  <= pick_idx;
                        cur_lane <= pick_addr[1:0];
                        cur_type <= pick_type;
                        mem_addr <= {pick_addr[31:2], 2'b00};
                        mem_req  <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        mem_req <= 1'b0;
                        // An accepted request still returns data that must be swallowed.
                        state   <= mem_ack ? S_DRAIN : S_IDLE;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        // Data arriving in the flush cycle itself leaves nothing to drain.
                        state <= mem_rvalid ? S_IDLE : S_DRAIN;
                    end else if (mem_rvalid) begin
                        result_data  <= ext_data;
                        result_line  <= cur_idx;
                        result_valid <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DRAIN: begin
                    mem_req <= 1'b0;
                    if (mem_rvalid) begin
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (flush || cdb_grant) begin
                        result_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    mem_req      <= 1'b0;
                    result_valid <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule
